// File: rtl/exe_stage.sv
// Execute stage: Val2 generation, ALU, NZCV status register, branch target
// and the EX/MEM pipeline register.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [31:0] pc_in,
  input  logic        wb_en_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        b_in,
  input  logic        s_in,
  input  logic        imm_in,
  input  logic [3:0]  exec_cmd_in,
  input  logic [31:0] val_rn_in,
  input  logic [31:0] val_rm_in,
  input  logic [3:0]  rd_in,
  input  logic [11:0] shift_operand_in,
  input  logic [23:0] signed_imm_24_in,
  output logic        branch_taken,
  output logic [31:0] branch_address,
  output logic [3:0]  status,
  output logic        wb_en_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [31:0] alu_result,
  output logic [31:0] val_rm_out,
  output logic [3:0]  rd_out
);

  typedef enum logic [3:0] {
    OP_MOV = 4'b0001,
    OP_MVN = 4'b1001,
    OP_ADD = 4'b0010,
    OP_ADC = 4'b0011,
    OP_SUB = 4'b0100,
    OP_SBC = 4'b0101,
    OP_AND = 4'b0110,
    OP_ORR = 4'b0111,
    OP_EOR = 4'b1000
  } alu_op_e;

  logic [31:0] val2;
  logic [31:0] imm8;
  logic [4:0]  imm_rot;
  logic [4:0]  sh_amt;
  logic [63:0] rot_dbl;

  logic [31:0] alu_res;
  logic [32:0] sum33;
  logic [31:0] b_inv;
  logic        cin;
  logic        flag_n;
  logic        flag_z;
  logic        flag_c;
  logic        flag_v;

  // Branch target: sign-extended word offset added to PC+4, wraps mod 2^32.
  always_comb begin
    branch_taken   = b_in;
    branch_address = pc_in + {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};
  end

  // Second operand generation; memory ops take the raw 12-bit offset first.
  // Rotations use a doubled word so a rotate by 0 needs no special case.
  always_comb begin
    val2    = val_rm_in;
    imm8    = {24'b0, shift_operand_in[7:0]};
    imm_rot = {shift_operand_in[11:8], 1'b0};
    sh_amt  = shift_operand_in[11:7];
    rot_dbl = '0;
    if (mem_read_in || mem_write_in) begin
      val2 = {20'b0, shift_operand_in};
    end else if (imm_in) begin
      rot_dbl = {imm8, imm8} >> imm_rot;
      val2    = rot_dbl[31:0];
    end else if (!shift_operand_in[4]) begin
      case (shift_operand_in[6:5])
        2'b00: val2 = val_rm_in << sh_amt;
        2'b01: val2 = val_rm_in >> sh_amt;
        2'b10: val2 = $signed(val_rm_in) >>> sh_amt;
        default: begin
          rot_dbl = {val_rm_in, val_rm_in} >> sh_amt;
          val2    = rot_dbl[31:0];
        end
      endcase
    end
  end

  // ALU with 33-bit arithmetic; logical ops and unknown codes keep C and V.
  always_comb begin
    cin     = status[1];
    b_inv   = ~val2;
    sum33   = '0;
    alu_res = '0;
    flag_c  = status[1];
    flag_v  = status[0];
    case (exec_cmd_in)
      OP_MOV: alu_res = val2;
      OP_MVN: alu_res = ~val2;
      OP_ADD: begin
        sum33   = {1'b0, val_rn_in} + {1'b0, val2};
        alu_res = sum33[31:0];
        flag_c  = sum33[32];
        flag_v  = (val_rn_in[31] == val2[31]) && (alu_res[31] != val_rn_in[31]);
      end
      OP_ADC: begin
        sum33   = {1'b0, val_rn_in} + {1'b0, val2} + {32'b0, cin};
        alu_res = sum33[31:0];
        flag_c  = sum33[32];
        flag_v  = (val_rn_in[31] == val2[31]) && (alu_res[31] != val_rn_in[31]);
      end
      OP_SUB: begin
        sum33   = {1'b0, val_rn_in} + {1'b0, b_inv} + 33'd1;
        alu_res = sum33[31:0];
        flag_c  = sum33[32];
        flag_v  = (val_rn_in[31] == b_inv[31]) && (alu_res[31] != val_rn_in[31]);
      end
      OP_SBC: begin
        sum33   = {1'b0, val_rn_in} + {1'b0, b_inv} + {32'b0, cin};
        alu_res = sum33[31:0];
        flag_c  = sum33[32];
        flag_v  = (val_rn_in[31] == b_inv[31]) && (alu_res[31] != val_rn_in[31]);
      end
      OP_AND: alu_res = val_rn_in & val2;
      OP_ORR: alu_res = val_rn_in | val2;
      OP_EOR: alu_res = val_rn_in ^ val2;
      default: alu_res = '0;
    endcase
    flag_n = alu_res[31];
    flag_z = (alu_res == '0);
  end

  // NZCV status register, updated only by unfrozen S instructions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status <= '0;
    end else if (s_in && !freeze) begin
      status <= {flag_n, flag_z, flag_c, flag_v};
    end
  end

  // EX/MEM pipeline register, held while the memory stage stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_out     <= 1'b0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
      alu_result    <= '0;
      val_rm_out    <= '0;
      rd_out        <= '0;
    end else if (!freeze) begin
      wb_en_out     <= wb_en_in;
      mem_read_out  <= mem_read_in;
      mem_write_out <= mem_write_in;
      alu_result    <= alu_res;
      val_rm_out    <= val_rm_in;
      rd_out        <= rd_in;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed, table-driven bench for the execute stage.
module tb_exe_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic [31:0] pc_in;
  logic        wb_en_in, mem_read_in, mem_write_in, b_in, s_in, imm_in;
  logic [3:0]  exec_cmd_in;
  logic [31:0] val_rn_in, val_rm_in;
  logic [3:0]  rd_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic [3:0]  status;
  logic        wb_en_out, mem_read_out, mem_write_out;
  logic [31:0] alu_result, val_rm_out;
  logic [3:0]  rd_out;

  int checks;
  int errors;

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .pc_in(pc_in),
    .wb_en_in(wb_en_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .exec_cmd_in(exec_cmd_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .rd_in(rd_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .branch_taken(branch_taken), .branch_address(branch_address), .status(status),
    .wb_en_out(wb_en_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .alu_result(alu_result), .val_rm_out(val_rm_out), .rd_out(rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  cmd;
    logic        s, imm, mr, mw, wb;
    logic [31:0] rn, rm;
    logic [11:0] so;
    logic [3:0]  rd;
    logic [31:0] exp_res;
    logic [3:0]  exp_st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [3:0] cmd, logic s, logic imm,
                              logic mr, logic mw, logic wb, logic [31:0] rn,
                              logic [31:0] rm, logic [11:0] so, logic [3:0] rd,
                              logic [31:0] exp_res, logic [3:0] exp_st);
    vec_t v;
    v.name = name; v.cmd = cmd; v.s = s; v.imm = imm; v.mr = mr; v.mw = mw;
    v.wb = wb; v.rn = rn; v.rm = rm; v.so = so; v.rd = rd;
    v.exp_res = exp_res; v.exp_st = exp_st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    exec_cmd_in = v.cmd; s_in = v.s; imm_in = v.imm; mem_read_in = v.mr;
    mem_write_in = v.mw; wb_en_in = v.wb; val_rn_in = v.rn; val_rm_in = v.rm;
    shift_operand_in = v.so; rd_in = v.rd;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".status"}, {28'b0, status}, 32'h0);
    chk({tag, ".alu"}, alu_result, 32'h0);
    chk({tag, ".rm"}, val_rm_out, 32'h0);
    chk({tag, ".rd"}, {28'b0, rd_out}, 32'h0);
    chk({tag, ".ctl"}, {29'b0, wb_en_out, mem_read_out, mem_write_out}, 32'h0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; freeze = 1'b0; pc_in = '0; b_in = 1'b0; signed_imm_24_in = '0;
    wb_en_in = 0; mem_read_in = 0; mem_write_in = 0; s_in = 0; imm_in = 0;
    exec_cmd_in = '0; val_rn_in = '0; val_rm_in = '0; rd_in = '0; shift_operand_in = '0;

    //        name    cmd     s  imm mr mw wb  rn            rm            so      rd     result        NZCV
    vecs.push_back(mk("adds_ovf", 4'b0010, 1, 1, 0, 0, 1, 32'h7FFFFFFF, 32'h0, 12'h001, 4'd1, 32'h80000000, 4'b1001));
    vecs.push_back(mk("subs_eq",  4'b0100, 1, 0, 0, 0, 0, 32'd5,        32'd5, 12'h000, 4'd2, 32'h00000000, 4'b0110));
    vecs.push_back(mk("adc_c1",   4'b0011, 0, 1, 0, 0, 1, 32'd1,        32'h0, 12'h001, 4'd3, 32'h00000003, 4'b0110));
    vecs.push_back(mk("mov_asr",  4'b0001, 1, 0, 0, 0, 1, 32'h0, 32'h80000001, 12'h0C0, 4'd4, 32'hC0000000, 4'b1010));
    vecs.push_back(mk("mov_ror",  4'b0001, 1, 0, 0, 0, 1, 32'h0, 32'h80000001, 12'h260, 4'd5, 32'h18000000, 4'b0010));
    vecs.push_back(mk("mov_imm",  4'b0001, 0, 1, 0, 0, 1, 32'h0,        32'h0, 12'h4FF, 4'd6, 32'hFF000000, 4'b0010));
    vecs.push_back(mk("ldr",      4'b0010, 0, 1, 1, 0, 1, 32'h100,      32'h0, 12'hFFF, 4'd7, 32'h000010FF, 4'b0010));
    vecs.push_back(mk("str",      4'b0010, 0, 0, 0, 1, 0, 32'h20, 32'hDEADBEEF, 12'h004, 4'd8, 32'h00000024, 4'b0010));
    vecs.push_back(mk("sbc_c1",   4'b0101, 1, 0, 0, 0, 1, 32'd10,       32'd3, 12'h000, 4'd9, 32'h00000007, 4'b0010));
    vecs.push_back(mk("subs_neg", 4'b0100, 1, 0, 0, 0, 1, 32'd3,        32'd5, 12'h000, 4'd10, 32'hFFFFFFFE, 4'b1000));
    vecs.push_back(mk("sbc_c0",   4'b0101, 1, 0, 0, 0, 1, 32'd10,       32'd3, 12'h000, 4'd11, 32'h00000006, 4'b0010));
    vecs.push_back(mk("adcs_wrap",4'b0011, 1, 1, 0, 0, 1, 32'hFFFFFFFF, 32'h0, 12'h000, 4'd12, 32'h00000000, 4'b0110));
    vecs.push_back(mk("ands",     4'b0110, 1, 0, 0, 0, 1, 32'hF0F0F0F0, 32'h0F0F0F0F, 12'h000, 4'd13, 32'h00000000, 4'b0110));
    vecs.push_back(mk("orrs",     4'b0111, 1, 0, 0, 0, 1, 32'hF0000000, 32'h0000000F, 12'h000, 4'd14, 32'hF000000F, 4'b1010));
    vecs.push_back(mk("eors",     4'b1000, 1, 0, 0, 0, 1, 32'hFFFF0000, 32'hFF00FF00, 12'h000, 4'd15, 32'h00FFFF00, 4'b0010));
    vecs.push_back(mk("lsl31",    4'b0001, 0, 0, 0, 0, 1, 32'h0, 32'h00000003, 12'hF80, 4'd1, 32'h80000000, 4'b0010));
    vecs.push_back(mk("lsr4",     4'b0001, 0, 0, 0, 0, 1, 32'h0, 32'h80000000, 12'h220, 4'd2, 32'h08000000, 4'b0010));
    vecs.push_back(mk("regshift", 4'b0001, 0, 0, 0, 0, 1, 32'h0, 32'h12345678, 12'h0B0, 4'd3, 32'h12345678, 4'b0010));
    vecs.push_back(mk("adds_negov",4'b0010,1, 0, 0, 0, 1, 32'h80000000, 32'h80000000, 12'h000, 4'd4, 32'h00000000, 4'b0111));
    vecs.push_back(mk("undef_op", 4'b1111, 1, 0, 0, 0, 1, 32'h12345678, 32'h1, 12'h000, 4'd5, 32'h00000000, 4'b0111));
    vecs.push_back(mk("cmp_ovf",  4'b0100, 1, 0, 0, 0, 0, 32'h80000000, 32'd1, 12'h000, 4'd6, 32'h7FFFFFFF, 4'b0011));
    vecs.push_back(mk("mvns_imm", 4'b1001, 1, 1, 0, 0, 1, 32'h0,        32'h0, 12'h4FF, 4'd7, 32'h00FFFFFF, 4'b0011));
    vecs.push_back(mk("bubble",   4'b0000, 0, 0, 0, 0, 0, 32'h0,        32'h0, 12'h000, 4'd0, 32'h00000000, 4'b0011));

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk({vecs[i].name, ".alu"}, alu_result, vecs[i].exp_res);
      chk({vecs[i].name, ".status"}, {28'b0, status}, {28'b0, vecs[i].exp_st});
      chk({vecs[i].name, ".ctl"}, {29'b0, wb_en_out, mem_read_out, mem_write_out},
          {29'b0, vecs[i].wb, vecs[i].mr, vecs[i].mw});
      chk({vecs[i].name, ".rd"}, {28'b0, rd_out}, {28'b0, vecs[i].rd});
      chk({vecs[i].name, ".rm"}, val_rm_out, vecs[i].rm);
    end

    // Branch target: combinational, same cycle.
    @(negedge clk);
    b_in = 1'b1; pc_in = 32'h40; signed_imm_24_in = 24'hFFFFFE;
    #1;
    chk("br_taken", {31'b0, branch_taken}, 32'd1);
    chk("br_back", branch_address, 32'h00000038);
    pc_in = 32'h0; signed_imm_24_in = 24'hFFFFFF;
    #1;
    chk("br_wrap", branch_address, 32'hFFFFFFFC);
    pc_in = 32'h100; signed_imm_24_in = 24'h000010; b_in = 1'b0;
    #1;
    chk("br_fwd", branch_address, 32'h00000140);
    chk("br_not_taken", {31'b0, branch_taken}, 32'd0);

    // Freeze: outputs and status hold while an ADDS with s=1 is presented.
    @(negedge clk);
    freeze = 1'b1;
    drive(mk("frz", 4'b0010, 1, 0, 0, 0, 1, 32'd1, 32'd1, 12'h000, 4'd9, 32'd2, 4'b0000));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("frz.alu", alu_result, 32'h0);
      chk("frz.status", {28'b0, status}, 32'h3);
      chk("frz.rd", {28'b0, rd_out}, 32'h0);
      @(negedge clk);
      val_rn_in = val_rn_in + 32'd7;
      val_rm_in = 32'hA5A5A5A5;
    end
    val_rn_in = 32'd1; val_rm_in = 32'd1;
    freeze = 1'b0;
    @(posedge clk);
    #1;
    chk("unfrz.alu", alu_result, 32'd2);
    chk("unfrz.status", {28'b0, status}, 32'h0);
    chk("unfrz.rd", {28'b0, rd_out}, 32'd9);
    chk("unfrz.wb", {31'b0, wb_en_out}, 32'd1);

    // Load a nonzero result, then assert reset between clock edges.
    @(negedge clk);
    drive(mk("pre_rst", 4'b0010, 1, 0, 1, 0, 1, 32'h80000000, 32'h55, 12'h800, 4'd12, 32'h80000800, 4'b1000));
    @(posedge clk);
    #1;
    chk("pre_rst.alu", alu_result, 32'h80000800);
    chk("pre_rst.status", {28'b0, status}, 32'h8);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
